// File: rtl/manchester_frame_extractor_if.sv
// rtl/manchester_frame_extractor_if.sv - FIFO write port between the frame extractor and the RX FIFO
interface manchester_frame_extractor_if;
  logic [7:0] e_data;
  logic       w_enable;
  logic       full;

  modport master (output e_data, output w_enable, input full);
  modport slave  (input e_data, input w_enable, output full);
endinterface

// File: rtl/manchester_frame_extractor.sv
// rtl/manchester_frame_extractor.sv - Manchester line decoder that locks on preamble/SFD and writes header bytes to a FIFO
module manchester_frame_extractor #(
  parameter int HALF_SAMPLES = 5,
  parameter int SKIP_BYTES   = 6,
  parameter int FIELD_BYTES  = 8,
  parameter int MAX_PAYLOAD  = 1504,
  parameter int CNT_W        = 11
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ethernet_in,
  input  logic                          pass_payload,
  manchester_frame_extractor_if.master  fifo,
  output logic                          frame_start,
  output logic                          frame_done,
  output logic                          frame_err,
  output logic [1:0]                    err_code,
  output logic [CNT_W-1:0]              byte_count
);
  localparam int TW  = $clog2(3 * HALF_SAMPLES + 1);
  localparam int T2W = TW + 1;
  localparam int SW  = $clog2(SKIP_BYTES + FIELD_BYTES + MAX_PAYLOAD + 2);

  // Edge classes are decided on 2*t so half-sample thresholds stay exact.
  localparam logic [T2W-1:0] T2_VIOL    = T2W'(HALF_SAMPLES);
  localparam logic [T2W-1:0] T2_MID     = T2W'(3 * HALF_SAMPLES);
  localparam logic [TW-1:0]  T_HALF     = TW'(HALF_SAMPLES);
  localparam logic [TW-1:0]  T_MAX      = TW'(3 * HALF_SAMPLES);
  localparam logic [SW-1:0]  SKIP_LAST  = SW'(SKIP_BYTES - 1);
  localparam logic [SW-1:0]  FIELD_LAST = SW'(FIELD_BYTES - 1);
  localparam logic [SW-1:0]  PAY_MAX    = SW'(MAX_PAYLOAD);

  typedef enum logic [2:0] {IDLE, HUNT, SKIP, FIELD, PAYLOAD, DROP} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [TW-1:0]    t;
  logic [15:0]      shift;
  logic [2:0]       bit_cnt;
  logic [SW-1:0]    seg_cnt;
  logic             pay_latch;
  logic             wr_pend;
  logic [7:0]       wr_byte;

  logic             edge_seen, viol, mid, loss, byte_done;
  logic             in_frame, write_due, err_now, err_to_idle;
  logic [1:0]       err_val;
  logic [15:0]      shift_nx;
  logic [CNT_W-1:0] bc_inc;

  // Classify the current line edge and pick the single error to report this cycle.
  always_comb begin
    edge_seen   = s2 ^ s3;
    viol        = edge_seen && ({t, 1'b0} < T2_VIOL);
    mid         = edge_seen && ({t, 1'b0} >= T2_MID);
    loss        = !edge_seen && (t == T_MAX - 1'b1);
    shift_nx    = {shift[14:0], s2};
    byte_done   = mid && (bit_cnt == 3'd7);
    bc_inc      = (byte_count == '1) ? byte_count : byte_count + 1'b1;
    in_frame    = (state == SKIP) || (state == FIELD) || (state == PAYLOAD);
    write_due   = wr_pend && in_frame;
    err_now     = 1'b0;
    err_val     = 2'b00;
    err_to_idle = 1'b0;
    if (in_frame) begin
      if (viol) begin
        err_now = 1'b1;
        err_val = 2'b01;
      end else if (loss && ((state != PAYLOAD) || (bit_cnt != 3'd0))) begin
        err_now     = 1'b1;
        err_val     = 2'b01;
        err_to_idle = 1'b1;
      end else if (write_due && fifo.full) begin
        err_now = 1'b1;
        err_val = 2'b10;
      end else if ((state == PAYLOAD) && byte_done && (seg_cnt == PAY_MAX)) begin
        err_now = 1'b1;
        err_val = 2'b11;
      end
    end
  end

  // Two-flop synchroniser followed by the previous-level register for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= ethernet_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Samples since the last mid-bit edge; the first edge after idle counts as a bit boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      t <= T_MAX;
    end else if ((state == IDLE) && edge_seen) begin
      t <= T_HALF;
    end else if ((state != IDLE) && mid) begin
      t <= '0;
    end else if (t < T_MAX) begin
      t <= t + 1'b1;
    end
  end

  // Frame FSM: bit assembly, byte routing, delayed FIFO write and error reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      shift         <= '0;
      bit_cnt       <= '0;
      seg_cnt       <= '0;
      pay_latch     <= 1'b0;
      wr_pend       <= 1'b0;
      wr_byte       <= '0;
      fifo.e_data   <= '0;
      fifo.w_enable <= 1'b0;
      frame_start   <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      err_code      <= '0;
      byte_count    <= '0;
    end else begin
      frame_start   <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      fifo.w_enable <= 1'b0;
      if (write_due && !err_now) begin
        fifo.w_enable <= 1'b1;
        fifo.e_data   <= wr_byte;
        wr_pend       <= 1'b0;
      end
      if (in_frame && mid) begin
        shift   <= shift_nx;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (err_now) begin
        frame_err <= 1'b1;
        err_code  <= err_val;
        wr_pend   <= 1'b0;
        state     <= err_to_idle ? IDLE : DROP;
        if (byte_done) byte_count <= bc_inc;
      end else begin
        case (state)
          IDLE: begin
            if (edge_seen) begin
              shift <= '0;
              state <= HUNT;
            end
          end
          HUNT: begin
            if (viol || loss) begin
              state <= IDLE;
            end else if (mid) begin
              shift <= shift_nx;
              if (shift_nx == 16'hAAAB) begin
                frame_start <= 1'b1;
                byte_count  <= '0;
                bit_cnt     <= '0;
                seg_cnt     <= '0;
                pay_latch   <= pass_payload;
                state       <= SKIP;
              end
            end
          end
          SKIP: begin
            if (byte_done) begin
              byte_count <= bc_inc;
              if (seg_cnt == SKIP_LAST) begin
                seg_cnt <= '0;
                state   <= FIELD;
              end else begin
                seg_cnt <= seg_cnt + 1'b1;
              end
            end
          end
          FIELD: begin
            if (byte_done) begin
              byte_count <= bc_inc;
              wr_pend    <= 1'b1;
              wr_byte    <= shift_nx[7:0];
              if (seg_cnt == FIELD_LAST) begin
                seg_cnt <= '0;
                state   <= PAYLOAD;
              end else begin
                seg_cnt <= seg_cnt + 1'b1;
              end
            end
          end
          PAYLOAD: begin
            if (loss) begin
              frame_done <= 1'b1;
              state      <= IDLE;
            end else if (byte_done) begin
              byte_count <= bc_inc;
              seg_cnt    <= seg_cnt + 1'b1;
              if (pay_latch) begin
                wr_pend <= 1'b1;
                wr_byte <= shift_nx[7:0];
              end
            end
          end
          DROP: begin
            if (loss) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_manchester_frame_extractor.sv
// tb/tb_manchester_frame_extractor.sv - directed self-checking bench for manchester_frame_extractor
module tb_manchester_frame_extractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line = 1'b1;
  logic full = 1'b0;
  logic pass = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_mid = 0;
  int mid_of [0:31];

  manchester_frame_extractor_if f0();
  manchester_frame_extractor_if f1();
  manchester_frame_extractor_if f2();
  assign f0.full = full;
  assign f1.full = full;
  assign f2.full = full;

  logic fs0, fd0, fe0, fs1, fd1, fe1, fs2, fd2, fe2;
  logic [1:0] ec0, ec1, ec2;
  logic [10:0] bc0, bc1, bc2;

  manchester_frame_extractor dut (
    .clk(clk), .rst(rst), .ethernet_in(line), .pass_payload(pass), .fifo(f0.master),
    .frame_start(fs0), .frame_done(fd0), .frame_err(fe0), .err_code(ec0), .byte_count(bc0));
  manchester_frame_extractor #(.MAX_PAYLOAD(4)) dut_small (
    .clk(clk), .rst(rst), .ethernet_in(line), .pass_payload(pass), .fifo(f1.master),
    .frame_start(fs1), .frame_done(fd1), .frame_err(fe1), .err_code(ec1), .byte_count(bc1));
  manchester_frame_extractor #(.HALF_SAMPLES(8)) dut_h8 (
    .clk(clk), .rst(rst), .ethernet_in(line), .pass_payload(pass), .fifo(f2.master),
    .frame_start(fs2), .frame_done(fd2), .frame_err(fe2), .err_code(ec2), .byte_count(bc2));

  int wr0 = 0, st0 = 0, dn0 = 0, er0 = 0;
  int wr1 = 0, dn1 = 0, er1 = 0;
  int wr2 = 0, dn2 = 0, er2 = 0;
  logic [7:0] wq0[$];
  logic [7:0] wq2[$];
  int wc0[$];
  int wc2[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (f0.w_enable) begin wr0++; wq0.push_back(f0.e_data); wc0.push_back(cyc); end
    if (fs0) st0++;
    if (fd0) dn0++;
    if (fe0) er0++;
    if (f1.w_enable) wr1++;
    if (fd1) dn1++;
    if (fe1) er1++;
    if (f2.w_enable) begin wr2++; wq2.push_back(f2.e_data); wc2.push_back(cyc); end
    if (fd2) dn2++;
    if (fe2) er2++;
  end

  task automatic send_half(input logic lvl, input int n);
    line = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int h, input bit glitch);
    send_half(!b, h);
    line = b;
    last_mid = cyc;
    if (glitch) begin
      repeat (2) @(negedge clk);
      line = !b;
      @(negedge clk);
      line = b;
      repeat (h - 3) @(negedge clk);
    end else begin
      repeat (h) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int h, input bit glitch);
    for (int i = 7; i >= 0; i--) send_bit(b[i], h, glitch && (i == 7));
  endtask

  // Preamble + SFD, 14 header bytes of FB, payload of 0F x4 then F0, then idle line.
  task automatic send_frame(input int h, input int n_pay, input int glitch_idx,
                            input int full_idx, input int abort_idx);
    logic [7:0] b;
    int lim;
    lim = (abort_idx >= 0) ? abort_idx : 14 + n_pay;
    for (int i = 0; i < 7; i++) send_byte(8'hAA, h, 1'b0);
    send_byte(8'hAB, h, 1'b0);
    for (int i = 0; i < lim; i++) begin
      b = (i < 14) ? 8'hFB : ((i - 14 < 4) ? 8'h0F : 8'hF0);
      if (i == full_idx) full = 1'b1;
      send_byte(b, h, i == glitch_idx);
      full = 1'b0;
      if (i < 32) mid_of[i] = last_mid;
    end
    if (abort_idx < 0) send_half(1'b1, 8 * h);
  endtask

  task automatic do_reset();
    rst = 1'b1; line = 1'b1; full = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (f0.w_enable !== 1'b0) begin n_fail++; $display("FAIL reset_w_enable: got %b expected 0", f0.w_enable); end
    n_checks++; if (f0.e_data !== 8'h00) begin n_fail++; $display("FAIL reset_e_data: got %h expected 00", f0.e_data); end
    n_checks++; if (fs0 !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b expected 0", fs0); end
    n_checks++; if (fd0 !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", fd0); end
    n_checks++; if (fe0 !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", fe0); end
    n_checks++; if (ec0 !== 2'b00) begin n_fail++; $display("FAIL reset_err_code: got %b expected 00", ec0); end
    n_checks++; if (bc0 !== 11'd0) begin n_fail++; $display("FAIL reset_byte_count: got %0d expected 0", bc0); end
  endtask

  task automatic test_basic();
    int w, d, e, s, q;
    w = wr0; d = dn0; e = er0; s = st0; q = wq0.size();
    pass = 1'b0;
    send_frame(5, 6, -1, -1, -1);
    n_checks++; if (wr0 - w !== 8) begin n_fail++; $display("FAIL basic_writes: got %0d expected 8", wr0 - w); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (wq0[q + i] !== 8'hFB) begin n_fail++; $display("FAIL basic_data[%0d]: got %h expected fb", i, wq0[q + i]); end
    end
    n_checks++; if (wc0[q] - mid_of[6] !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d expected 4", wc0[q] - mid_of[6]); end
    n_checks++; if (st0 - s !== 1) begin n_fail++; $display("FAIL basic_start: got %0d expected 1", st0 - s); end
    n_checks++; if (dn0 - d !== 1) begin n_fail++; $display("FAIL basic_done: got %0d expected 1", dn0 - d); end
    n_checks++; if (er0 - e !== 0) begin n_fail++; $display("FAIL basic_err: got %0d expected 0", er0 - e); end
    n_checks++; if (bc0 !== 11'd20) begin n_fail++; $display("FAIL basic_byte_count: got %0d expected 20", bc0); end
  endtask

  task automatic test_payload();
    int w, d, q;
    logic [7:0] exp_b;
    w = wr0; d = dn0; q = wq0.size();
    pass = 1'b1;
    send_frame(5, 6, -1, -1, -1);
    pass = 1'b0;
    n_checks++; if (wr0 - w !== 14) begin n_fail++; $display("FAIL payload_writes: got %0d expected 14", wr0 - w); end
    for (int i = 0; i < 14; i++) begin
      exp_b = (i < 8) ? 8'hFB : ((i < 12) ? 8'h0F : 8'hF0);
      n_checks++; if (wq0[q + i] !== exp_b) begin n_fail++; $display("FAIL payload_data[%0d]: got %h expected %h", i, wq0[q + i], exp_b); end
    end
    n_checks++; if (dn0 - d !== 1) begin n_fail++; $display("FAIL payload_done: got %0d expected 1", dn0 - d); end
  endtask

  task automatic test_full();
    int w, d, e;
    w = wr0; d = dn0; e = er0;
    pass = 1'b0;
    send_frame(5, 6, -1, 8, -1);
    n_checks++; if (wr0 - w !== 2) begin n_fail++; $display("FAIL full_writes: got %0d expected 2", wr0 - w); end
    n_checks++; if (er0 - e !== 1) begin n_fail++; $display("FAIL full_err_pulses: got %0d expected 1", er0 - e); end
    n_checks++; if (ec0 !== 2'b10) begin n_fail++; $display("FAIL full_err_code: got %b expected 10", ec0); end
    n_checks++; if (dn0 - d !== 0) begin n_fail++; $display("FAIL full_done: got %0d expected 0", dn0 - d); end
  endtask

  task automatic test_glitch();
    int w, d, e;
    w = wr0; d = dn0; e = er0;
    pass = 1'b0;
    send_frame(5, 6, 12, -1, -1);
    n_checks++; if (wr0 - w !== 6) begin n_fail++; $display("FAIL glitch_writes: got %0d expected 6", wr0 - w); end
    n_checks++; if (er0 - e !== 1) begin n_fail++; $display("FAIL glitch_err_pulses: got %0d expected 1", er0 - e); end
    n_checks++; if (ec0 !== 2'b01) begin n_fail++; $display("FAIL glitch_err_code: got %b expected 01", ec0); end
    n_checks++; if (dn0 - d !== 0) begin n_fail++; $display("FAIL glitch_done: got %0d expected 0", dn0 - d); end
  endtask

  task automatic test_oversize();
    int w, d, e;
    do_reset();
    pass = 1'b1;
    w = wr1; d = dn1; e = er1;
    send_frame(5, 4, -1, -1, -1);
    n_checks++; if (er1 - e !== 0) begin n_fail++; $display("FAIL limit_err: got %0d expected 0", er1 - e); end
    n_checks++; if (dn1 - d !== 1) begin n_fail++; $display("FAIL limit_done: got %0d expected 1", dn1 - d); end
    n_checks++; if (wr1 - w !== 12) begin n_fail++; $display("FAIL limit_writes: got %0d expected 12", wr1 - w); end
    n_checks++; if (bc1 !== 11'd18) begin n_fail++; $display("FAIL limit_byte_count: got %0d expected 18", bc1); end
    w = wr1; d = dn1; e = er1;
    send_frame(5, 5, -1, -1, -1);
    pass = 1'b0;
    n_checks++; if (er1 - e !== 1) begin n_fail++; $display("FAIL oversize_err_pulses: got %0d expected 1", er1 - e); end
    n_checks++; if (ec1 !== 2'b11) begin n_fail++; $display("FAIL oversize_err_code: got %b expected 11", ec1); end
    n_checks++; if (bc1 !== 11'd19) begin n_fail++; $display("FAIL oversize_byte_count: got %0d expected 19", bc1); end
    n_checks++; if (wr1 - w !== 12) begin n_fail++; $display("FAIL oversize_writes: got %0d expected 12", wr1 - w); end
    n_checks++; if (dn1 - d !== 0) begin n_fail++; $display("FAIL oversize_done: got %0d expected 0", dn1 - d); end
  endtask

  task automatic test_reset_mid_frame();
    int w, d, e;
    d = dn0; e = er0;
    pass = 1'b0;
    send_frame(5, 6, -1, -1, 8);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    line = 1'b1;
    rst = 1'b0;
    repeat (60) @(negedge clk);
    n_checks++; if (dn0 - d !== 0) begin n_fail++; $display("FAIL rst_done: got %0d expected 0", dn0 - d); end
    n_checks++; if (er0 - e !== 0) begin n_fail++; $display("FAIL rst_err: got %0d expected 0", er0 - e); end
    n_checks++; if (bc0 !== 11'd0) begin n_fail++; $display("FAIL rst_byte_count: got %0d expected 0", bc0); end
    n_checks++; if (ec0 !== 2'b00) begin n_fail++; $display("FAIL rst_err_code: got %b expected 00", ec0); end
    w = wr0; d = dn0; e = er0;
    send_frame(5, 6, -1, -1, -1);
    n_checks++; if (wr0 - w !== 8) begin n_fail++; $display("FAIL rst_again_writes: got %0d expected 8", wr0 - w); end
    n_checks++; if (dn0 - d !== 1) begin n_fail++; $display("FAIL rst_again_done: got %0d expected 1", dn0 - d); end
    n_checks++; if (er0 - e !== 0) begin n_fail++; $display("FAIL rst_again_err: got %0d expected 0", er0 - e); end
  endtask

  task automatic test_half8();
    int w, d, e, q;
    do_reset();
    w = wr2; d = dn2; e = er2; q = wq2.size();
    pass = 1'b0;
    send_frame(8, 6, -1, -1, -1);
    n_checks++; if (wr2 - w !== 8) begin n_fail++; $display("FAIL h8_writes: got %0d expected 8", wr2 - w); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (wq2[q + i] !== 8'hFB) begin n_fail++; $display("FAIL h8_data[%0d]: got %h expected fb", i, wq2[q + i]); end
    end
    n_checks++; if (wc2[q] - mid_of[6] !== 4) begin n_fail++; $display("FAIL h8_latency: got %0d expected 4", wc2[q] - mid_of[6]); end
    n_checks++; if (dn2 - d !== 1) begin n_fail++; $display("FAIL h8_done: got %0d expected 1", dn2 - d); end
    n_checks++; if (er2 - e !== 0) begin n_fail++; $display("FAIL h8_err: got %0d expected 0", er2 - e); end
    n_checks++; if (bc2 !== 11'd20) begin n_fail++; $display("FAIL h8_byte_count: got %0d expected 20", bc2); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_payload();
    test_full();
    test_glitch();
    test_oversize();
    test_reset_mid_frame();
    test_half8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
